// File: rtl/sd_request_arbiter_pkg.sv
// sd_arb_pkg: shared state/direction types and index helpers for sd_request_arbiter.
package sd_arb_pkg;
    localparam int LBA_W = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_XFER} state_t;
    typedef enum logic {DIR_RD, DIR_WR} dir_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction
endpackage

// File: rtl/sd_request_arbiter_if.sv
// sd_request_arbiter_if: requester and hps_io sd_* signals; slave = arbiter side, master = environment side.
interface sd_request_arbiter_if
    import sd_arb_pkg::*;
#(
    parameter int NDRV = 4
);
    logic [NDRV*LBA_W-1:0] req_lba, sd_lba;
    logic [NDRV-1:0] req_rd, req_wr, req_done, req_err, req_busy, buf_wr, sd_rd, sd_wr, sd_ack;
    logic sd_buff_wr, active;
    modport slave (
        input  req_lba, req_rd, req_wr, sd_ack, sd_buff_wr,
        output req_done, req_err, req_busy, buf_wr, sd_lba, sd_rd, sd_wr, active
    );
    modport master (
        output req_lba, req_rd, req_wr, sd_ack, sd_buff_wr,
        input  req_done, req_err, req_busy, buf_wr, sd_lba, sd_rd, sd_wr, active
    );
endinterface

// File: rtl/sd_request_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder, first pending slot at or after i_rr.
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NDRV = 4,
    localparam int IW = idx_w(NDRV)
) (
    input  logic [NDRV-1:0] i_pend,
    input  logic [IW-1:0]   i_rr,
    output logic            o_hit,
    output logic [IW-1:0]   o_idx
);
    assign o_hit = |i_pend;
    // Scan farthest-first so the slot nearest to i_rr is the last (winning) assignment.
    always_comb begin
        o_idx = '0;
        for (int k = NDRV - 1; k >= 0; k--)
            if (i_pend[wrap_add(int'(i_rr), k, NDRV)]) o_idx = IW'(wrap_add(int'(i_rr), k, NDRV));
    end
endmodule

// File: rtl/sd_request_arbiter.sv
// sd_request_arbiter: serialises per-drive sector requests onto hps_io sd_rd/sd_wr, one at a time, round-robin.
// Define SD_TIMEOUT_EN to add an sd_ack watchdog that aborts stalled transfers with req_err.
module sd_request_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NDRV = 4
`ifdef SD_TIMEOUT_EN
    , parameter logic [23:0] ACK_TIMEOUT = 24'd12000000
`endif
) (
    input  logic sysclk,
    input  logic rstn,
    sd_request_arbiter_if.slave bus
);
    localparam int IW = idx_w(NDRV);
    state_t r_state;
    dir_t r_dir;
    logic [IW-1:0] r_idx, r_rr, w_idx;
    logic [LBA_W-1:0] r_lba;
    logic [NDRV*LBA_W-1:0] r_sd_lba;
    logic [NDRV-1:0] r_sd_rd, r_sd_wr, r_busy, r_done, r_err, r_ack_q, w_pend;
    logic w_hit, w_ack, w_ack_ok, w_fall, w_end, w_to;

    assign w_pend = bus.req_rd | bus.req_wr;
    assign w_ack  = bus.sd_ack[r_idx];
    assign w_fall = r_ack_q[r_idx] & ~w_ack;
    assign w_end  = (r_state == ST_XFER) && w_fall;

    rr_pick #(.NDRV(NDRV)) u_pick (.i_pend(w_pend), .i_rr(r_rr), .o_hit(w_hit), .o_idx(w_idx));

`ifdef SD_TIMEOUT_EN
    logic [23:0] r_cnt;
    assign w_to = (r_cnt == ACK_TIMEOUT);
    // A late ack left high from an aborted transfer must fall before it can count again.
    assign w_ack_ok = w_ack & ~r_ack_q[r_idx];
    always_ff @(posedge sysclk or negedge rstn)
        if (!rstn) r_cnt <= '0;
        else if ((r_state != ST_WAIT_ACK && r_state != ST_XFER) || w_to || (w_ack ^ r_ack_q[r_idx]) || bus.sd_buff_wr)
            r_cnt <= '0;
        else r_cnt <= r_cnt + 24'd1;
`else
    assign w_to = 1'b0;
    assign w_ack_ok = w_ack;
`endif

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_dir    <= DIR_RD;
            r_idx    <= '0;
            r_rr     <= '0;
            r_lba    <= '0;
            r_sd_lba <= '0;
            r_sd_rd  <= '0;
            r_sd_wr  <= '0;
            r_busy   <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_ack_q  <= '0;
        end else begin
            r_ack_q <= bus.sd_ack;
            r_done  <= '0;
            r_err   <= '0;
            case (r_state)
                ST_IDLE: if (w_hit) begin
                    r_idx         <= w_idx;
                    r_lba         <= bus.req_lba[LBA_W*w_idx +: LBA_W];
                    r_dir         <= bus.req_rd[w_idx] ? DIR_RD : DIR_WR;
                    r_busy[w_idx] <= 1'b1;
                    r_state       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_sd_lba[LBA_W*r_idx +: LBA_W] <= r_lba;
                    r_sd_rd[r_idx] <= (r_dir == DIR_RD);
                    r_sd_wr[r_idx] <= (r_dir == DIR_WR);
                    r_state        <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK, ST_XFER: if (w_end || w_to) begin
                    r_sd_rd        <= '0;
                    r_sd_wr        <= '0;
                    r_sd_lba       <= '0;
                    r_busy[r_idx]  <= 1'b0;
                    r_done[r_idx]  <= w_end;
                    r_err[r_idx]   <= ~w_end;
                    r_rr           <= (r_idx == IW'(NDRV - 1)) ? '0 : r_idx + IW'(1);
                    r_state        <= ST_IDLE;
                end else if (r_state == ST_WAIT_ACK && w_ack_ok) begin
                    r_sd_rd <= '0;
                    r_sd_wr <= '0;
                    r_state <= ST_XFER;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sd_rd    = r_sd_rd;
    assign bus.sd_wr    = r_sd_wr;
    assign bus.sd_lba   = r_sd_lba;
    assign bus.req_busy = r_busy;
    assign bus.req_done = r_done;
    assign bus.req_err  = r_err;
    assign bus.active   = (r_state != ST_IDLE);
    assign bus.buf_wr   = (r_state == ST_XFER && bus.sd_buff_wr && w_ack) ? NDRV'(1) << r_idx : '0;
endmodule

// File: tb/tb_sd_request_arbiter.sv
// tb_sd_request_arbiter: table-driven single transfers plus directed round-robin, collision, stray-ack and reset sequences.
module tb_sd_request_arbiter;
    logic sysclk, rstn;
    int total = 0, bad = 0, lat, n, g;
    logic [3:0] rdv, wrv, donev;
    logic [127:0] lbav, exp_l;
    int own, other;

    sd_request_arbiter_if #(.NDRV(4)) bus ();

    sd_request_arbiter #(
        .NDRV(4)
`ifdef SD_TIMEOUT_EN
        , .ACK_TIMEOUT(24'd100)
`endif
    ) dut (
        .sysclk(sysclk),
        .rstn(rstn),
        .bus(bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        int drv; logic wr; logic [31:0] lba; int nbuf;
        int exp_lat; logic [3:0] exp_rd; logic [3:0] exp_wr; int exp_bufs; logic [3:0] exp_done;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic wait_issue(output int t);
        t = 0;
        while ((bus.sd_rd | bus.sd_wr) == 4'b0 && t < 50) begin
            tick;
            t++;
        end
        check("issue_bound", t < 50, 1);
    endtask

    // Plays the hps_io side of one transfer and reports what it observed.
    task automatic hps_serve(input int ack_dly, input int nbuf, output int gi, output int li,
                             output logic [3:0] r, output logic [3:0] w, output logic [127:0] l,
                             output int o, output int x, output logic [3:0] d);
        gi = 0; o = 0; x = 0; d = '0; r = '0; w = '0; l = '0;
        wait_issue(li);
        if (li >= 50) return;
        r = bus.sd_rd; w = bus.sd_wr; l = bus.sd_lba;
        for (int i = 0; i < 4; i++) if (r[i] | w[i]) gi = i;
        check("one_outstanding", $countones(r | w), 1);
        repeat (ack_dly) tick;
        check("hold_until_ack", bus.sd_rd | bus.sd_wr, r | w);
        bus.sd_ack[gi] = 1'b1;
        tick;
        check("drop_after_ack", bus.sd_rd | bus.sd_wr, 0);
        bus.sd_buff_wr = 1'b1;
        for (int i = 0; i < nbuf; i++) begin
            #3;
            o += int'(bus.buf_wr[gi]);
            x += $countones(bus.buf_wr & ~(4'(1) << gi));
            @(posedge sysclk);
            #1;
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack[gi] = 1'b0;
        tick;
        d = bus.req_done;
        check("busy_clear", bus.req_busy[gi], 0);
        check("no_err", bus.req_err, 0);
    endtask

    initial begin
        vecs[0] = '{2, 1'b0, 32'h0000_1234, 512, 1, 4'b0100, 4'b0000, 512, 4'b0100};
        vecs[1] = '{0, 1'b1, 32'hDEAD_BEEF,   3, 1, 4'b0000, 4'b0001,   3, 4'b0001};
        vecs[2] = '{3, 1'b0, 32'hFFFF_FFFF,   1, 1, 4'b1000, 4'b0000,   1, 4'b1000};
        vecs[3] = '{1, 1'b1, 32'h0000_0000,   0, 1, 4'b0000, 4'b0010,   0, 4'b0010};

        rstn = 1'b0;
        bus.req_lba = '0; bus.req_rd = '0; bus.req_wr = '0; bus.sd_ack = '0; bus.sd_buff_wr = 1'b0;
        repeat (3) tick;
        check("rst_sd_rd", bus.sd_rd, 0);
        check("rst_sd_wr", bus.sd_wr, 0);
        check("rst_lba", bus.sd_lba, 0);
        check("rst_busy", bus.req_busy, 0);
        check("rst_done", bus.req_done, 0);
        check("rst_err", bus.req_err, 0);
        check("rst_active", bus.active, 0);
        rstn = 1'b1;
        tick;

        for (int v = 0; v < 4; v++) begin
            bus.req_lba[32*vecs[v].drv +: 32] = vecs[v].lba;
            if (vecs[v].wr) bus.req_wr[vecs[v].drv] = 1'b1;
            else bus.req_rd[vecs[v].drv] = 1'b1;
            tick;
            check("grant_busy", bus.req_busy, 4'(1) << vecs[v].drv);
            check("no_early_issue", bus.sd_rd | bus.sd_wr, 0);
            check("active_on", bus.active, 1);
            hps_serve(5, vecs[v].nbuf, g, lat, rdv, wrv, lbav, own, other, donev);
            exp_l = '0;
            exp_l[32*vecs[v].drv +: 32] = vecs[v].lba;
            check("issue_latency", lat, vecs[v].exp_lat);
            check("vec_sd_rd", rdv, vecs[v].exp_rd);
            check("vec_sd_wr", wrv, vecs[v].exp_wr);
            check("vec_sd_lba", lbav, exp_l);
            check("vec_buf_own", own, vecs[v].exp_bufs);
            check("vec_buf_other", other, 0);
            check("vec_done", donev, vecs[v].exp_done);
            bus.req_rd = '0; bus.req_wr = '0;
            tick;
            check("done_one_cycle", bus.req_done, 0);
            check("active_off", bus.active, 0);
        end

        // Reset in the middle of a data phase; rr was left at 2 by the table.
        bus.req_lba[95:64] = 32'h0000_5555;
        bus.req_rd[2] = 1'b1;
        wait_issue(lat);
        bus.sd_ack[2] = 1'b1;
        tick;
        bus.sd_buff_wr = 1'b1;
        #2;
        check("xfer_before_reset", bus.buf_wr, 4'b0100);
        rstn = 1'b0;
        #1;
        check("async_busy", bus.req_busy, 0);
        check("async_active", bus.active, 0);
        check("async_buf_wr", bus.buf_wr, 0);
        check("async_sd_rd", bus.sd_rd, 0);
        bus.sd_buff_wr = 1'b0; bus.sd_ack = '0; bus.req_rd = '0;
        tick;
        check("no_done_in_reset", bus.req_done, 0);
        rstn = 1'b1;
        tick;
        bus.req_lba[63:32] = 32'h0000_0011;
        bus.req_lba[127:96] = 32'h0000_0033;
        bus.req_rd = 4'b1010;
        hps_serve(2, 2, g, lat, rdv, wrv, lbav, own, other, donev);
        check("rr_after_reset", g, 1);
        bus.req_rd[1] = 1'b0;
        hps_serve(2, 2, g, lat, rdv, wrv, lbav, own, other, donev);
        check("rr_after_reset_2", g, 3);
        bus.req_rd[3] = 1'b0;

        // Round-robin with all four pending, then 0 and 3 re-requested.
        for (int i = 0; i < 4; i++) bus.req_lba[32*i +: 32] = 32'h100 + i;
        bus.req_rd = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            hps_serve(1, 2, g, lat, rdv, wrv, lbav, own, other, donev);
            check("rr_order", g, k);
            check("rr_done", donev, 4'(1) << k);
            bus.req_rd[g] = 1'b0;
        end
        bus.req_rd = 4'b1001;
        hps_serve(1, 1, g, lat, rdv, wrv, lbav, own, other, donev);
        check("rr_second_0", g, 0);
        bus.req_rd[0] = 1'b0;
        hps_serve(1, 1, g, lat, rdv, wrv, lbav, own, other, donev);
        check("rr_second_3", g, 3);
        bus.req_rd[3] = 1'b0;

        // Read and write both requested by drive 1: read first, then write with the same LBA.
        bus.req_lba[63:32] = 32'h0000_0ABC;
        bus.req_rd[1] = 1'b1;
        bus.req_wr[1] = 1'b1;
        hps_serve(1, 2, g, lat, rdv, wrv, lbav, own, other, donev);
        check("coll_rd_first", rdv, 4'b0010);
        check("coll_no_wr", wrv, 4'b0000);
        bus.req_rd[1] = 1'b0;
        hps_serve(1, 2, g, lat, rdv, wrv, lbav, own, other, donev);
        check("coll_wr_second", wrv, 4'b0010);
        check("coll_wr_lba", lbav[63:32], 32'h0000_0ABC);
        check("coll_done", donev, 4'b0010);
        bus.req_wr[1] = 1'b0;

        // Stray ack and buffer writes from drive 3 while drive 0 is serviced.
        bus.req_lba[31:0] = 32'h0000_0777;
        bus.req_rd[0] = 1'b1;
        wait_issue(lat);
        bus.sd_ack[3] = 1'b1;
        tick;
        tick;
        check("stray_ack_wait", bus.sd_rd, 4'b0001);
        bus.sd_ack[0] = 1'b1;
        tick;
        check("own_ack_drop", bus.sd_rd, 0);
        bus.sd_buff_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            check("stray_buf", bus.buf_wr, 4'b0001);
            @(posedge sysclk);
            #1;
        end
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack[3] = 1'b0;
        tick;
        check("stray_fall_no_done", bus.req_done, 0);
        check("stray_still_active", bus.active, 1);
        bus.sd_ack[0] = 1'b0;
        tick;
        check("stray_done", bus.req_done, 4'b0001);
        bus.req_rd[0] = 1'b0;
        tick;

`ifdef SD_TIMEOUT_EN
        bus.req_lba[95:64] = 32'h0000_0ABC;
        bus.req_rd[2] = 1'b1;
        wait_issue(lat);
        n = 0;
        while (bus.req_err == 4'b0 && n < 300) begin
            tick;
            n++;
        end
        check("to_err", bus.req_err, 4'b0100);
        check("to_window", (n >= 99 && n <= 102), 1);
        check("to_rd_drop", bus.sd_rd, 0);
        check("to_idle", bus.active, 0);
        check("to_no_done", bus.req_done, 0);
        bus.sd_ack[2] = 1'b1;
        wait_issue(lat);
        repeat (3) tick;
        check("late_ack_ignored", bus.sd_rd, 4'b0100);
        bus.sd_ack[2] = 1'b0;
        tick;
        bus.sd_ack[2] = 1'b1;
        tick;
        check("fresh_ack_drop", bus.sd_rd, 0);
        bus.sd_ack[2] = 1'b0;
        tick;
        check("to_retry_done", bus.req_done, 4'b0100);
        bus.req_rd[2] = 1'b0;
        tick;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
